// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: channel mode encodings shared by the LED PWM controller.
package led_pwm_pkg;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_OFF     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_STATIC  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 2'd3;
endpackage

// File: rtl/led_pwm_envelope.sv
// led_pwm_envelope: prescaled tick, shared triangle envelope and blink phase.
module led_pwm_envelope #(
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 1024,
  parameter int BLINK_TICKS = 128
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] env_o,
  output logic                blink_phase_o,
  output logic                tick_o
);
  localparam int PS_W = $clog2(PRESCALE);
  localparam int BT_W = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [BT_W-1:0] BT_MAX = BT_W'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] ENV_MAX = '1;
  logic [PS_W-1:0] pre_q, pre_d;
  logic [BT_W-1:0] bcnt_q, bcnt_d;
  logic [PWM_BITS-1:0] env_q, env_d;
  logic dir_q, dir_d, phase_q, phase_d, tick, bwrap;
  always_comb begin
    tick    = pre_q == PS_MAX;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    env_d   = !tick ? env_q : dir_q ? env_q - 1'b1 : env_q + 1'b1;
    // direction flips on the tick that lands on an extreme, so env never wraps
    dir_d   = !tick ? dir_q : dir_q ? (env_d != '0) : (env_d == ENV_MAX);
    bwrap   = tick & (bcnt_q == BT_MAX);
    bcnt_d  = bwrap ? '0 : tick ? bcnt_q + 1'b1 : bcnt_q;
    phase_d = phase_q ^ bwrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      bcnt_q  <= '0;
      env_q   <= '0;
      dir_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      bcnt_q  <= bcnt_d;
      env_q   <= env_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
    end
  end
  assign env_o         = env_q;
  assign blink_phase_o = phase_q;
  assign tick_o        = tick;
endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: N_CH-channel PWM LED driver with double-buffered per-channel
// mode/duty configuration committed at each PWM period boundary.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 1024,
  parameter int BLINK_TICKS = 128,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic [N_CH-1:0]     led
);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  logic [PWM_BITS-1:0] pwm_cnt_q, env;
  logic blink_phase, tick_unused, commit, accept, err_q;
  led_pwm_envelope #(
    .PWM_BITS   (PWM_BITS),
    .PRESCALE   (PRESCALE),
    .BLINK_TICKS(BLINK_TICKS)
  ) u_env (
    .clk          (clk),
    .rst          (rst),
    .env_o        (env),
    .blink_phase_o(blink_phase),
    .tick_o       (tick_unused)
  );
  // ready drops in the commit cycle so a write can never race the copy
  assign commit    = pwm_cnt_q == CNT_MAX;
  assign cfg_ready = ~rst & ~commit;
  assign accept    = cfg_valid & cfg_ready;
  assign cfg_err   = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      err_q     <= accept & ({1'b0, cfg_ch} >= (CH_W + 1)'(N_CH));
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [MODE_W-1:0] pmode_q, amode_q;
    logic [PWM_BITS-1:0] pduty_q, aduty_q, breathe, eff;
    logic wr, on_q;
    assign wr = accept & (cfg_ch == CH_W'(i));
    always_comb begin
      breathe = PWM_BITS'(({{PWM_BITS{1'b0}}, aduty_q} * {{PWM_BITS{1'b0}}, env}) >> PWM_BITS);
      eff     = amode_q == MODE_OFF    ? '0 :
                amode_q == MODE_STATIC ? aduty_q :
                amode_q == MODE_BLINK  ? (blink_phase ? aduty_q : '0) : breathe;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        pmode_q <= MODE_OFF;
        pduty_q <= '0;
        amode_q <= MODE_OFF;
        aduty_q <= '0;
        on_q    <= 1'b0;
      end else begin
        if (wr) begin
          pmode_q <= cfg_mode;
          pduty_q <= cfg_duty;
        end
        if (commit) begin
          amode_q <= pmode_q;
          aduty_q <= pduty_q;
        end
        on_q <= eff > pwm_cnt_q;
      end
    end
    assign led[i] = on_q;
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: randomized scoreboard bench against a time-indexed reference model.
module tb_led_pwm_ctrl;
  localparam int N_CH = 6, PW = 4, PS = 3, BT = 2, CH_W = 3, MAXC = (1 << PW) - 1;
  logic clk = 0, rst = 1, cfg_valid = 0, cfg_ready, cfg_err;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [PW-1:0] cfg_duty = '0;
  logic [N_CH-1:0] led;
  always #5 clk = ~clk;
  led_pwm_ctrl #(.N_CH(N_CH), .PWM_BITS(PW), .PRESCALE(PS), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_err(cfg_err), .led(led)
  );
  typedef struct {
    logic [N_CH-1:0] led;
    logic err;
    int pwm;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int t = 0;
  int pmode[N_CH], pduty[N_CH], amode[N_CH], aduty[N_CH];
  // t counts cycles since reset release; every timed quantity is derived from it
  function automatic int env_at(int k);
    int r = k % (2 * MAXC);
    return r <= MAXC ? r : 2 * MAXC - r;
  endfunction
  function automatic int eff(int ch);
    int k = t / PS;
    case (amode[ch])
      0: return 0;
      1: return aduty[ch];
      2: return ((k / BT) % 2) ? aduty[ch] : 0;
      default: return (aduty[ch] * env_at(k)) >> PW;
    endcase
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask
  always @(posedge clk) begin : model
    exp_t e;
    int pwm;
    bit acc;
    if (rst) begin
      t = 0;
      for (int c = 0; c < N_CH; c++) begin
        pmode[c] = 0; pduty[c] = 0; amode[c] = 0; aduty[c] = 0;
      end
      e.led = '0;
      e.err = 1'b0;
    end else begin
      pwm = t % (MAXC + 1);
      acc = cfg_valid && pwm != MAXC;
      for (int c = 0; c < N_CH; c++) e.led[c] = eff(c) > pwm;
      e.err = acc && cfg_ch >= N_CH;
      if (acc && cfg_ch < N_CH) begin
        pmode[cfg_ch] = cfg_mode;
        pduty[cfg_ch] = cfg_duty;
      end
      if (pwm == MAXC)
        for (int c = 0; c < N_CH; c++) begin
          amode[c] = pmode[c];
          aduty[c] = pduty[c];
        end
      t++;
    end
    e.pwm = t % (MAXC + 1);
    sb.push_back(e);
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("led", 32'(led), 32'(e.led));
      chk("cfg_err", 32'(cfg_err), 32'(e.err));
      chk("cfg_ready", 32'(cfg_ready), 32'(!rst && e.pwm != MAXC));
    end
  end
  task automatic wr(int ch, int mode, int duty);
    bit r;
    @(posedge clk); #1;
    cfg_valid = 1; cfg_ch = CH_W'(ch); cfg_mode = 2'(mode); cfg_duty = PW'(duty);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); r = cfg_ready;
      @(posedge clk);
      if (r) break;
      if (i == 39) chk("wr_timeout", 32'(r), 32'd1);
    end
    #1 cfg_valid = 0;
  endtask
  initial begin
    int hold = 0;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    repeat (200) @(posedge clk);
    wr(3, 1, 4);
    repeat (60) @(posedge clk);
    wr(0, 2, 15);
    wr(1, 1, 0);
    wr(2, 3, 15);
    wr(7, 1, 9);
    wr(4, 1, 15);
    wr(4, 1, 7);
    repeat (300) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (100) @(posedge clk);
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 199) == 0;
      if (hold == 0) begin
        cfg_valid = $urandom_range(0, 2) == 0;
        cfg_ch    = CH_W'($urandom_range(0, 7));
        cfg_mode  = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: cfg_duty = '0;
          1: cfg_duty = '1;
          default: cfg_duty = PW'($urandom);
        endcase
        hold = $urandom_range(0, 3);
      end else hold--;
    end
    @(posedge clk); #1 rst = 0; cfg_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
